prog_loader_ram: RTL and testbench
==================================

// Module: prog_loader_ram
// PURPOSE
//  Parametrised program RAM with a built-in loader FSM. It is the successor to the fixed 16x8 DFF RAM and its
//  control-block programming handshake. In programming mode it takes bytes from the dedicated input pins on strobe
//  edges and writes them to consecutive addresses. In run mode it serves as CPU RAM behind the MAR.
//  It sits between the pin interface (ui_in/uio) and the CPU bus/MAR.
// PARAMETERS
//  DATA_W      8   word width (bus width)
//  ADDR_W      4   address width; depth = 2**ADDR_W
//  LOAD_WORDS  16  words per programming session; legal range 1..2**ADDR_W
// PORTS
//  clk         in   1       clock; all state on rising edge
//  rst_n       in   1       asynchronous active-low reset
//  programming in   1       programming-mode request (pin, asynchronous)
//  strobe      in   1       data strobe from pin (asynchronous); a word is taken on each rising edge
//  data_in     in   DATA_W  load data (pins); sampled together with the synchronised strobe edge
//  ready       out  1       high while in LOAD (loader accepts strobes)
//  done_load   out  1       high in DONE (LOAD_WORDS words written)
//  load_addr   out  ADDR_W  next address the loader writes
//  cpu_addr    in   ADDR_W  CPU address (from MAR)
//  cpu_wdata   in   DATA_W  CPU write data (from MAR data)
//  cpu_we_n    in   1       CPU write enable, active-low
//  cpu_rdata   out  DATA_W  registered read data
//  checksum    out  DATA_W  only with PROG_CHECKSUM_EN
// BEHAVIOUR
//  Reset: state=IDLE, ready=0, done_load=0, load_addr=0, cpu_rdata=0, sync flops=0, checksum=0.
//   Memory contents are not reset.
//  programming and strobe each pass through a 2-flop synchroniser. strobe edge = sync_q & ~sync_q_d.
//  data_in is captured on the same edge as strobe enters stage 1, so it must be stable across the strobe rise.
//  FSM:
//   IDLE: ready=0. Goes to LOAD when synced programming=1. On entry: load_addr=0.
//   LOAD: ready=1. On each strobe edge: mem[load_addr]<=data; load_addr++.
//    The LOAD_WORDS-th write goes to DONE.
//    If programming drops, go to IDLE: done_load stays 0, words already written are kept, load_addr=0.
//   DONE: done_load=1, ready=0; strobe edges are ignored.
//    When programming drops, go to IDLE and clear done_load.
//  Latency: the memory write occurs 3 clk after the strobe rises at the pin (2 sync + edge).
//   ready falls on the clk the last word is written.
//  load_addr wraps mod 2**ADDR_W. With LOAD_WORDS=2**ADDR_W the final increment wraps to 0 as the FSM enters DONE.
//  CPU port:
//   cpu_rdata <= mem[cpu_addr] every clk (1-cycle read latency), in every state.
//   Writes happen only in IDLE when cpu_we_n=0.
//   cpu_we_n=0 in LOAD/DONE is ignored; the loader has priority and there is no stall output.
//   Read-during-write to the same address (IDLE) returns the old data.
//  A programming strobe edge and a programming drop in the same clk: the drop wins and no write occurs.
//  Async reset mid-LOAD: FSM returns to IDLE immediately; a partially loaded image stays in memory.
// CONFIGURATION
//  PROG_CHECKSUM_EN defined:
//   checksum port exists and is cleared on entry to LOAD.
//   checksum ^= data on every accepted write.
//   It holds its value in DONE and IDLE until the next LOAD entry.
//  PROG_CHECKSUM_EN undefined: no checksum port, no checksum register. All other behaviour is identical.
// TESTING
//  1 Reset: hold rst_n=0 -> ready=0, done_load=0, load_addr=0, cpu_rdata=0.
//    Release with programming=0 -> state stays IDLE.
//  2 Full load, defaults: programming=1, 16 strobes with data 8'h10+i
//    -> mem[i]=8'h10+i, done_load=1 after the 16th write, ready=0.
//    Then programming=0 -> done_load=0, and cpu_addr=5 gives cpu_rdata=8'h15 one clk later.
//  3 Abort: programming=1, 3 strobes (AA,BB,CC), then programming=0 -> IDLE, done_load=0, mem[0..2]=AA,BB,CC.
//    Re-enter -> load_addr=0.
//  4 Ignored writes: in LOAD, cpu_we_n=0, cpu_addr=9, wdata=8'h77 -> mem[9] unchanged.
//    In IDLE the same access -> mem[9]=8'h77.
//  5 Strobe hygiene: strobe held high 10 clk -> exactly one write.
//    Strobes arriving in DONE -> no write, load_addr unchanged.
//  6 PROG_CHECKSUM_EN, ADDR_W=3, LOAD_WORDS=4: data 01,02,04,08 -> checksum=8'h0F at done_load.
//    load_addr=4. A second session clears checksum to 0 on entry.

Source files
------------

// File: rtl/prog_loader_ram.sv
// Program RAM with a pin-driven loader: bytes strobed in on the pins fill consecutive words, then the CPU uses it as RAM.
// Optional build macro PROG_CHECKSUM_EN adds an XOR checksum of the words loaded in the current session.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | CPU owns the RAM; waiting for the synchronised programming request
// LOAD  | loader accepts strobe edges and writes consecutive addresses
// DONE  | LOAD_WORDS words written; strobes ignored until programming drops
module prog_loader_ram #(
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 4,
   parameter int LOAD_WORDS = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              programming,
   input  logic              strobe,
   input  logic [DATA_W-1:0] data_in,
   output logic              ready,
   output logic              done_load,
   output logic [ADDR_W-1:0] load_addr,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_we_n,
`ifdef PROG_CHECKSUM_EN
   output logic [DATA_W-1:0] checksum,
`endif
   output logic [DATA_W-1:0] cpu_rdata
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LOAD_WORDS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              prog_s1, prog_s2;
   logic              strb_s1, strb_s2, strb_s2_d;
   logic [DATA_W-1:0] data_s1, data_s2;
   logic              strb_edge;
   logic              load_we;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem [DEPTH];

   // data rides a two-stage pipe alongside strobe so the word lines up with its edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prog_s1   <= 1'b0;
         prog_s2   <= 1'b0;
         strb_s1   <= 1'b0;
         strb_s2   <= 1'b0;
         strb_s2_d <= 1'b0;
         data_s1   <= '0;
         data_s2   <= '0;
      end else begin
         prog_s1   <= programming;
         prog_s2   <= prog_s1;
         strb_s1   <= strobe;
         strb_s2   <= strb_s1;
         strb_s2_d <= strb_s2;
         data_s1   <= data_in;
         data_s2   <= data_s1;
      end
   end

   assign strb_edge = strb_s2 & ~strb_s2_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
      end
   end

   // a programming drop outranks a coincident strobe edge
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      load_we = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (prog_s2) begin
               state_d = ST_LOAD;
               addr_d  = '0;
            end
         end
         ST_LOAD: begin
            if (!prog_s2) begin
               state_d = ST_IDLE;
               addr_d  = '0;
            end else if (strb_edge) begin
               load_we = 1'b1;
               addr_d  = addr_q + ADDR_W'(1);
               if (addr_q == LAST_ADDR) state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (!prog_s2) begin
               state_d = ST_IDLE;
               addr_d  = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            addr_d  = '0;
         end
      endcase
   end

   assign ready     = (state_q == ST_LOAD);
   assign done_load = (state_q == ST_DONE);
   assign load_addr = addr_q;

   assign mem_we    = load_we | ((state_q == ST_IDLE) & ~cpu_we_n);
   assign mem_waddr = load_we ? addr_q  : cpu_addr;
   assign mem_wdata = load_we ? data_s2 : cpu_wdata;

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cpu_rdata <= '0;
      else        cpu_rdata <= mem[cpu_addr];
   end

`ifdef PROG_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                            checksum <= '0;
      else if (state_q == ST_IDLE && prog_s2) checksum <= '0;
      else if (load_we)                      checksum <= checksum ^ data_s2;
   end
`endif

endmodule

// File: tb/tb_prog_loader_ram.sv
// Bench for prog_loader_ram: a default 16-word instance plus a small 8-deep, 4-word instance sharing the same pins.
// Checks against a word-level model of the loader session and RAM contents.
module tb_prog_loader_ram;
   localparam int LW  = 16;
   localparam int SLW = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       programming = 1'b0;
   logic       strobe = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic [3:0] cpu_addr = 4'h0;
   logic [7:0] cpu_wdata = 8'h00;
   logic       cpu_we_n = 1'b1;
   logic       ready, done_load, s_ready, s_done;
   logic [3:0] load_addr;
   logic [2:0] s_load_addr;
   logic [7:0] cpu_rdata, s_rdata;
`ifdef PROG_CHECKSUM_EN
   logic [7:0] checksum, s_checksum;
`endif

   prog_loader_ram #(.DATA_W(8), .ADDR_W(4), .LOAD_WORDS(LW)) dut (
      .clk(clk), .rst_n(rst_n), .programming(programming), .strobe(strobe), .data_in(data_in),
      .ready(ready), .done_load(done_load), .load_addr(load_addr),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we_n(cpu_we_n),
`ifdef PROG_CHECKSUM_EN
      .checksum(checksum),
`endif
      .cpu_rdata(cpu_rdata));

   prog_loader_ram #(.DATA_W(8), .ADDR_W(3), .LOAD_WORDS(SLW)) dut_s (
      .clk(clk), .rst_n(rst_n), .programming(programming), .strobe(strobe), .data_in(data_in),
      .ready(s_ready), .done_load(s_done), .load_addr(s_load_addr),
      .cpu_addr(cpu_addr[2:0]), .cpu_wdata(cpu_wdata), .cpu_we_n(cpu_we_n),
`ifdef PROG_CHECKSUM_EN
      .checksum(s_checksum),
`endif
      .cpu_rdata(s_rdata));

   always #5 clk = ~clk;

   // reference model: session flags, next address, word count, checksum, RAM image
   logic [7:0] m_mem [16];
   bit         m_val [16];
   bit         m_load, m_done, s_load, s_dn;
   int         m_addr, m_cnt, s_addr, s_cnt;
   logic [7:0] m_cks, s_cks;
   int         vectors = 0;
   int         miscompares = 0;

   typedef struct {
      logic [7:0] data;
      logic [3:0] addr;
      bit         rdy;
      bit         dn;
   } vec_t;
   vec_t tbl [16];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_reset();
      m_load = 0; m_done = 0; m_addr = 0; m_cnt = 0; m_cks = 8'h00;
      s_load = 0; s_dn = 0; s_addr = 0; s_cnt = 0; s_cks = 8'h00;
   endtask

   task automatic model_prog(input bit b);
      if (b) begin
         if (!m_load && !m_done) begin m_load = 1; m_addr = 0; m_cnt = 0; m_cks = 8'h00; end
         if (!s_load && !s_dn)   begin s_load = 1; s_addr = 0; s_cnt = 0; s_cks = 8'h00; end
      end else begin
         m_load = 0; m_done = 0; m_addr = 0;
         s_load = 0; s_dn = 0; s_addr = 0;
      end
   endtask

   task automatic model_strobe(input logic [7:0] d);
      if (m_load) begin
         m_mem[m_addr] = d; m_val[m_addr] = 1; m_cks ^= d;
         m_addr = (m_addr + 1) % 16; m_cnt++;
         if (m_cnt == LW) begin m_load = 0; m_done = 1; end
      end
      if (s_load) begin
         s_cks ^= d; s_addr = (s_addr + 1) % 8; s_cnt++;
         if (s_cnt == SLW) begin s_load = 0; s_dn = 1; end
      end
   endtask

   task automatic check_state(input string tag);
      chk({tag, " ready"}, 32'(ready), 32'(m_load));
      chk({tag, " done_load"}, 32'(done_load), 32'(m_done));
      chk({tag, " load_addr"}, 32'(load_addr), 32'(m_addr));
      chk({tag, " s_ready"}, 32'(s_ready), 32'(s_load));
      chk({tag, " s_done"}, 32'(s_done), 32'(s_dn));
      chk({tag, " s_load_addr"}, 32'(s_load_addr), 32'(s_addr));
`ifdef PROG_CHECKSUM_EN
      chk({tag, " checksum"}, 32'(checksum), 32'(m_cks));
      chk({tag, " s_checksum"}, 32'(s_checksum), 32'(s_cks));
`endif
   endtask

   task automatic set_prog(input bit b);
      programming = b;
      tick(4);
      model_prog(b);
   endtask

   task automatic pulse(input logic [7:0] d, input int hi);
      data_in = d;
      tick(1);
      strobe = 1'b1;
      tick(hi);
      strobe = 1'b0;
      tick(4);
      model_strobe(d);
   endtask

   task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
      logic [7:0] old;
      bit         oldv;
      old = m_mem[a]; oldv = m_val[a];
      cpu_addr = a; cpu_wdata = d; cpu_we_n = 1'b0;
      tick(1);
      cpu_we_n = 1'b1;
      if (oldv) chk("read_during_write", 32'(cpu_rdata), 32'(old));
      if (!m_load && !m_done) begin m_mem[a] = d; m_val[a] = 1; end
   endtask

   task automatic cpu_read(input logic [3:0] a);
      cpu_addr = a;
      tick(1);
      if (m_val[a]) chk("cpu_read", 32'(cpu_rdata), 32'(m_mem[a]));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 16; i++) begin m_mem[i] = 8'h00; m_val[i] = 0; end
      model_reset();
      for (int i = 0; i < 16; i++) begin
         tbl[i].data = 8'h10 + 8'(i);
         tbl[i].addr = 4'((i + 1) % 16);
         tbl[i].rdy  = (i != 15);
         tbl[i].dn   = (i == 15);
      end

      // reset values while held, then released with programming low
      tick(3);
      chk("rst ready", 32'(ready), 32'd0);
      chk("rst done_load", 32'(done_load), 32'd0);
      chk("rst load_addr", 32'(load_addr), 32'd0);
      chk("rst cpu_rdata", 32'(cpu_rdata), 32'd0);
      chk("rst s_rdata", 32'(s_rdata), 32'd0);
      rst_n = 1'b1;
      tick(5);
      check_state("idle_after_rst");

      // full 16-word load from the table
      set_prog(1);
      check_state("load_entry");
      for (int i = 0; i < 16; i++) begin
         pulse(tbl[i].data, 1);
         chk("tbl load_addr", 32'(load_addr), 32'(tbl[i].addr));
         chk("tbl ready", 32'(ready), 32'(tbl[i].rdy));
         chk("tbl done_load", 32'(done_load), 32'(tbl[i].dn));
      end
      pulse(8'hEE, 2);
      check_state("strobe_in_done");
      set_prog(0);
      check_state("done_exit");
      cpu_read(4'd5);
      chk("mem5 const", 32'(cpu_rdata), 32'h15);
      for (int i = 0; i < 16; i++) cpu_read(4'(i));

      // abort after three words, then re-enter
      set_prog(1);
      pulse(8'hAA, 1); pulse(8'hBB, 2); pulse(8'hCC, 1);
      set_prog(0);
      check_state("abort");
      for (int i = 0; i < 3; i++) cpu_read(4'(i));
      set_prog(1);
      check_state("reenter");

      // CPU writes ignored in LOAD, honoured in IDLE
      cpu_write(4'd9, 8'h77);
      cpu_read(4'd9);
      chk("mem9 kept", 32'(cpu_rdata), 32'h19);
      set_prog(0);
      cpu_write(4'd9, 8'h77);
      cpu_read(4'd9);
      chk("mem9 written", 32'(cpu_rdata), 32'h77);

      // long strobe gives one write; drop coinciding with a strobe gives none
      set_prog(1);
      pulse(8'h3C, 10);
      check_state("long_strobe");
      data_in = 8'hE7;
      tick(1);
      strobe = 1'b1; programming = 1'b0;
      tick(3);
      strobe = 1'b0;
      tick(4);
      model_prog(0);
      check_state("drop_vs_strobe");
      cpu_read(4'd0); cpu_read(4'd1);

      // async reset mid-load keeps the partial image
      set_prog(1);
      pulse(8'h61, 1); pulse(8'h62, 1); pulse(8'h63, 1);
      #2 rst_n = 1'b0;
      #1 chk("async rst ready", 32'(ready), 32'd0);
      programming = 1'b0;
      tick(2);
      rst_n = 1'b1;
      model_reset();
      tick(3);
      check_state("after_async_rst");
      for (int i = 0; i < 4; i++) cpu_read(4'(i));

      // small instance: four words complete its session; checksum restarts on re-entry
      set_prog(1);
      pulse(8'h01, 1); pulse(8'h02, 1); pulse(8'h04, 1); pulse(8'h08, 1);
      check_state("small_done");
      chk("small load_addr const", 32'(s_load_addr), 32'd4);
`ifdef PROG_CHECKSUM_EN
      chk("small checksum const", 32'(s_checksum), 32'h0F);
`endif
      set_prog(0);
      set_prog(1);
      check_state("small_second_session");

      // randomized mix of sessions, strobes and CPU traffic
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 5))
            0:       set_prog(1'($urandom_range(0, 1)));
            1, 2, 3: pulse(8'($urandom), int'($urandom_range(1, 4)));
            4:       cpu_write(4'($urandom), 8'($urandom));
            default: cpu_read(4'($urandom));
         endcase
         check_state("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
